// File: rtl/adc_sample_framer.sv
// rtl/adc_sample_framer.sv - buffers ADC samples in a FIFO and emits fixed-length frames on a valid/ready stream
// Define ADC_FRAMER_CHECKSUM_EN to append the XOR checksum trailer word to each frame.
module adc_sample_framer #(
  parameter int unsigned FRAME_LEN   = 16,
  parameter int unsigned FIFO_DEPTH  = 32,
  parameter logic [15:0] HEADER_WORD = 16'hADC7
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic                        Start_In,
  input  logic [15:0]                 Sample_In,
  input  logic                        Sample_In_En,
  output logic [15:0]                 Out_Data,
  output logic                        Out_Valid,
  input  logic                        Out_Ready,
  output logic [$clog2(FIFO_DEPTH):0] Fifo_Level,
  output logic                        Overflow,
  output logic [15:0]                 Drop_Cnt
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL  = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] FRAME_LVL = LW'(FRAME_LEN);
  localparam logic [7:0]    LAST_IDX  = 8'(FRAME_LEN - 1);

`ifdef ADC_FRAMER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_HEADER, S_FNUM, S_DATA, S_TRAILER} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_HEADER, S_FNUM, S_DATA} state_t;
`endif

  state_t          state_q, state_d;
  logic [15:0]     out_data_q, out_data_d;
  logic            out_valid_q, out_valid_d;
  logic [15:0]     fnum_q, fnum_d;
  logic [7:0]      idx_q, idx_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            ovf_q, ovf_d;
  logic [15:0]     drop_q, drop_d;
`ifdef ADC_FRAMER_CHECKSUM_EN
  logic [15:0]     csum_q, csum_d;
`endif
  logic [15:0]     mem [FIFO_DEPTH];
  logic            wr_en, drop, pop, hs;

  // Fullness uses the registered level, so a same-cycle pop never rescues a write.
  assign wr_en = Sample_In_En && Start_In && (level_q != FULL_LVL);
  assign drop  = Sample_In_En && Start_In && (level_q == FULL_LVL);
  assign hs    = out_valid_q && Out_Ready;

  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    fnum_d      = fnum_q;
    idx_d       = idx_q;
    pop         = 1'b0;
`ifdef ADC_FRAMER_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (level_q >= FRAME_LVL) begin
          state_d     = S_HEADER;
          out_data_d  = HEADER_WORD;
          out_valid_d = 1'b1;
        end
      end
      S_HEADER: begin
        if (hs) begin
          state_d    = S_FNUM;
          out_data_d = fnum_q;
        end
      end
      S_FNUM: begin
        if (hs) begin
          state_d    = S_DATA;
          out_data_d = mem[rd_ptr_q];
          pop        = 1'b1;
          idx_d      = 8'd0;
`ifdef ADC_FRAMER_CHECKSUM_EN
          csum_d     = 16'h0000;
`endif
        end
      end
      S_DATA: begin
        if (hs) begin
`ifdef ADC_FRAMER_CHECKSUM_EN
          csum_d = csum_q ^ out_data_q;
`endif
          if (idx_q == LAST_IDX) begin
`ifdef ADC_FRAMER_CHECKSUM_EN
            state_d    = S_TRAILER;
            out_data_d = csum_q ^ out_data_q;
`else
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            fnum_d      = fnum_q + 16'd1;
`endif
          end else begin
            idx_d      = idx_q + 8'd1;
            out_data_d = mem[rd_ptr_q];
            pop        = 1'b1;
          end
        end
      end
`ifdef ADC_FRAMER_CHECKSUM_EN
      S_TRAILER: begin
        if (hs) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          fnum_d      = fnum_q + 16'd1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q;
    if (wr_en && !pop) level_d = level_q + LW'(1);
    if (!wr_en && pop) level_d = level_q - LW'(1);
    ovf_d  = ovf_q | drop;
    drop_d = (drop && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= S_IDLE;
      out_data_q  <= 16'h0000;
      out_valid_q <= 1'b0;
      fnum_q      <= 16'h0000;
      idx_q       <= 8'd0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      level_q     <= '0;
      ovf_q       <= 1'b0;
      drop_q      <= 16'h0000;
`ifdef ADC_FRAMER_CHECKSUM_EN
      csum_q      <= 16'h0000;
`endif
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      fnum_q      <= fnum_d;
      idx_q       <= idx_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      level_q     <= level_d;
      ovf_q       <= ovf_d;
      drop_q      <= drop_d;
`ifdef ADC_FRAMER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  always_ff @(posedge Clk) begin
    if (wr_en) mem[wr_ptr_q] <= Sample_In;
  end

  assign Out_Data   = out_data_q;
  assign Out_Valid  = out_valid_q;
  assign Fifo_Level = level_q;
  assign Overflow   = ovf_q;
  assign Drop_Cnt   = drop_q;
endmodule
